mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative multiply/divide unit for the multicycle CPU, sitting directly downstream of the register file read ports. It consumes the two source operands (RD1/RD2) for MULT/MULTU/DIV/DIVU, computes over 32 iterations, and holds results in architectural HI/LO registers. It also services MTHI/MTLO writes. Control sequences the multi-cycle stall via busy/done.

## Interface
Parameters:
- WIDTH, 32, operand width; fixed at 32, not intended to be overridden.

Ports (clock and reset first):
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  launch operation in op; sampled only when not busy
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  32  rs operand (register file RD1); multiplicand/dividend; also MTHI/MTLO data
- src_b  in  32  rt operand (register file RD2); multiplier/divisor
- hi_we  in  1  MTHI: HI <= src_a
- lo_we  in  1  MTLO: LO <= src_a
- busy  out  1  operation in progress (CALC or FIX)
- done  out  1  one-cycle pulse, HI/LO hold new result
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, CALC, FIX, DONE. Single 6-bit iteration counter.
- IDLE/DONE + start=1: latch |src_a|, |src_b| (signed ops take two's-complement magnitude; unsigned ops pass through), latch result signs, counter <= 0, go CALC. hi_we/lo_we ignored that cycle (start wins).
- DIV/DIVU with src_b==0: skip CALC, go straight to FIX; result HI=src_a (as supplied), LO=32'hFFFFFFFF, for both signed and unsigned.
- CALC multiply: radix-2 shift-add on 64-bit {acc, mplier} using a 33-bit adder, one multiplier bit per cycle.
- CALC divide: restoring division on 64-bit {rem, quot}; shift left, trial-subtract divisor (33-bit), set quotient bit if non-negative.
- CALC exits to FIX after counter reaches 31 (32 iterations).
- FIX: apply signs, write HI/LO. MULT: negate 64-bit product if sign_a^sign_b. DIV: quotient negated if sign_a^sign_b, remainder takes sign of dividend. Unsigned ops: no correction. Go DONE.
- DIV 32'h80000000 / 32'hFFFFFFFF: magnitude result truncates to LO=32'h80000000, HI=0; no trap, no flag.
- DONE: done=1 for this cycle only; return to IDLE unless start=1 (back-to-back accepted).
- IDLE/DONE with hi_we/lo_we and no start: HI/LO written from src_a at the edge; both may write same cycle.
- start, hi_we, lo_we while busy: ignored, no queueing.

## Timing
- Reset (async assert, any state, incl. mid-CALC): state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, in-flight operation discarded.
- Normal op: start sampled at edge E0; busy=1 from E0 through E33; HI/LO updated at E33; done=1, busy=0 in cycle after E33. Total 34 cycles to done.
- Divide-by-zero: busy=1 after E0, HI/LO updated at E1, done in cycle after E1.
- hi/lo outputs are registered; they change only at FIX edge, MTHI/MTLO edge, or reset. Intermediate CALC state never visible on hi/lo.
- busy and done are decoded from registered state (no combinational path from inputs).

## Structure
- Package mdu_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state encoding, ITER_COUNT=32.
- Single module; no sub-module. Datapath (magnitude, shift/add, sign fix) and FSM in one file.

## Test plan
- MULT 32'hFFFFFFFF * 32'h3 -> HI=FFFFFFFF, LO=FFFFFFFD; MULTU same -> HI=00000002, LO=FFFFFFFD; done exactly 34 cycles after start.
- DIV 32'hFFFFFFF9 (-7) / 2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
- DIVU 32'h1234 / 0 -> HI=00001234, LO=FFFFFFFF, done 2 cycles after start; DIV 32'h80000000 / FFFFFFFF -> LO=80000000, HI=0.
- MTHI src_a=32'hA5A5A5A5 in IDLE -> hi=A5A5A5A5 next cycle; start pulses and lo_we asserted mid-CALC -> ignored, result of original op unaffected.
- Back-to-back: start held high through DONE -> second op accepted in DONE cycle, busy reasserts next cycle.
- rst_n asserted at cycle 10 of CALC -> busy, done, hi, lo all 0 immediately (asynchronous); no done pulse after release.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int DATA_W     = 32;
    localparam int ITER_COUNT = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Two's-complement magnitude when neg is set, pass-through otherwise.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic              neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting; accepts start or MTHI/MTLO writes
// CALC  | 32 shift-add (mult) or restoring-divide iterations
// FIX   | sign correction, HI/LO written at the end of this cycle
// DONE  | done pulse; accepts a back-to-back start or MTHI/MTLO
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import mdu_pkg::*;

    localparam logic [5:0] LAST_ITER = 6'(ITER_COUNT - 1);

    state_t             state, state_nxt;
    logic [5:0]         cnt;
    logic [2*WIDTH-1:0] pr;        // {acc, mplier} or {rem, quot}
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
    logic               sign_a, sign_b, is_div, div_zero;

    logic               can_accept, accept;
    logic               op_div, op_signed, op_div0;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign can_accept = (state == ST_IDLE) || (state == ST_DONE);
    assign accept     = can_accept && start;
    assign op_div     = (op == OP_DIV) || (op == OP_DIVU);
    assign op_signed  = (op == OP_MULT) || (op == OP_DIV);
    assign op_div0    = op_div && (src_b == '0);

    assign busy = (state == ST_CALC) || (state == ST_FIX);
    assign done = (state == ST_DONE);

    // One multiplier bit per cycle; the low bit of the sum shifts into the mplier half.
    assign mul_sum = {1'b0, pr[2*WIDTH-1:WIDTH]} + (pr[0] ? {1'b0, opnd} : '0);

    // Trial subtract of the shifted remainder. When rem[31] is set the shifted value
    // always exceeds the divisor and the difference stays below 2^32, so bit 32 is a
    // valid borrow flag in every case.
    assign div_trial = {pr[2*WIDTH-1:WIDTH], pr[WIDTH-1]} - {1'b0, opnd};

    assign prod_neg = ~pr + 1'b1;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept) state_nxt = op_div0 ? ST_FIX : ST_CALC;
            ST_CALC: if (cnt == LAST_ITER) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: begin
                if (accept) state_nxt = op_div0 ? ST_FIX : ST_CALC;
                else        state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch and per-iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            pr       <= '0;
            opnd     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            sign_a   <= op_signed && src_a[WIDTH-1];
            sign_b   <= op_signed && src_b[WIDTH-1];
            is_div   <= op_div;
            div_zero <= op_div0;
            if (op_div0) begin
                // Result is fixed: raw dividend to HI, all-ones to LO.
                pr   <= {src_a, {WIDTH{1'b1}}};
                opnd <= '0;
            end else if (op_div) begin
                pr   <= {{WIDTH{1'b0}}, magnitude(src_a, op_signed && src_a[WIDTH-1])};
                opnd <= magnitude(src_b, op_signed && src_b[WIDTH-1]);
            end else begin
                pr   <= {{WIDTH{1'b0}}, magnitude(src_b, op_signed && src_b[WIDTH-1])};
                opnd <= magnitude(src_a, op_signed && src_a[WIDTH-1]);
            end
        end else if (state == ST_CALC) begin
            cnt <= cnt + 6'd1;
            if (is_div) begin
                if (!div_trial[WIDTH]) pr <= {div_trial[WIDTH-1:0], pr[WIDTH-2:0], 1'b1};
                else                   pr <= {pr[2*WIDTH-2:0], 1'b0};
            end else begin
                pr <= {mul_sum, pr[WIDTH-1:1]};
            end
        end
    end

    // Sign correction of the magnitude result.
    always_comb begin
        res_hi = pr[2*WIDTH-1:WIDTH];
        res_lo = pr[WIDTH-1:0];
        if (div_zero) begin
            res_hi = pr[2*WIDTH-1:WIDTH];
            res_lo = pr[WIDTH-1:0];
        end else if (is_div) begin
            if (sign_a ^ sign_b) res_lo = prod_neg[WIDTH-1:0];
            if (sign_a)          res_hi = ~pr[2*WIDTH-1:WIDTH] + 1'b1;
        end else if (sign_a ^ sign_b) begin
            res_hi = prod_neg[2*WIDTH-1:WIDTH];
            res_lo = prod_neg[WIDTH-1:0];
        end
    end

    // Architectural HI/LO: result write in FIX, MTHI/MTLO only when no start is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (state == ST_FIX) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (can_accept && !start) begin
            if (hi_we) hi <= src_a;
            if (lo_we) lo <= src_a;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed scoreboard bench for mul_div_unit.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0, src_b = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_hi"}, {32'b0, hi}, {32'b0, e.hi});
                chk({e.name, "_lo"}, {32'b0, lo}, {32'b0, e.lo});
                chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
                chk({e.name, "_busy_low"}, {63'b0, busy}, 64'd0);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int lat,
                         input string nm);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        sb.push_back('{eh, el, cyc + lat, nm});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int n);
        int k = 0;
        while (sb.size() > n && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk("drain_timeout", 64'(sb.size() > n), 64'd0);
    endtask

    initial begin
        int c0;
        #12;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_hi", {32'b0, hi}, 64'd0);
        chk("rst_lo", {32'b0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(OP_MULT,  32'hFFFFFFFF, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, "mult");
        wait_drain(0);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'h3, 32'h00000002, 32'hFFFFFFFD, 34, "multu");
        wait_drain(0);
        issue(OP_DIV,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, "div");
        wait_drain(0);
        issue(OP_DIVU,  32'h7,        32'h2, 32'h00000001, 32'h00000003, 34, "divu");
        wait_drain(0);
        issue(OP_DIVU,  32'h1234,     32'h0, 32'h00001234, 32'hFFFFFFFF, 2,  "divu_by0");
        wait_drain(0);
        issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 34, "div_ovf");
        wait_drain(0);

        // MTHI in IDLE
        @(negedge clk);
        hi_we = 1'b1; src_a = 32'hA5A5A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_hi", {32'b0, hi}, {32'b0, 32'hA5A5A5A5});
        chk("mthi_lo_kept", {32'b0, lo}, {32'b0, 32'h80000000});

        // Start/MTHI/MTLO while busy are ignored
        issue(OP_MULTU, 32'd7, 32'd9, 32'h0, 32'd63, 34, "multu_ignore");
        repeat (4) @(negedge clk);
        start = 1'b1; op = OP_DIV; src_a = 32'hDEADBEEF; src_b = 32'h0;
        hi_we = 1'b1; lo_we = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk("busy_hi_kept", {32'b0, hi}, {32'b0, 32'hA5A5A5A5});
        chk("busy_lo_kept", {32'b0, lo}, {32'b0, 32'h80000000});
        wait_drain(0);

        // Back-to-back: start held through DONE
        @(negedge clk);
        c0 = cyc;
        start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
        sb.push_back('{32'd2, 32'd14, c0 + 34, "b2b_first"});
        @(negedge clk);
        op = OP_MULT; src_a = 32'hFFFFFFFE; src_b = 32'd5;
        sb.push_back('{32'hFFFFFFFF, 32'hFFFFFFF6, c0 + 68, "b2b_second"});
        begin
            int k = 0;
            while (sb.size() > 1 && k < 200) begin
                @(posedge clk);
                k++;
            end
        end
        #1;
        chk("b2b_busy_again", {63'b0, busy}, 64'd1);
        start = 1'b0;
        wait_drain(0);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'b0, busy}, 64'd0);
        chk("arst_done", {63'b0, done}, 64'd0);
        chk("arst_hi", {32'b0, hi}, 64'd0);
        chk("arst_lo", {32'b0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("arst_idle_after", {63'b0, busy}, 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
